// File: rtl/spi_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_wb_arbiter
// Description : Round-robin Wishbone arbiter that shares one SPI master core
//               between two requesters, with a stalled-strobe timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_wb_arbiter #(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      m_cyc_i,
  input  logic [1:0]      m_stb_i,
  input  logic [1:0]      m_we_i,
  input  logic [2*AW-1:0] m_adr_i,
  input  logic [2*DW-1:0] m_dat_i,
  output logic [DW-1:0]   m_dat_o,
  output logic [1:0]      m_ack_o,
  output logic [1:0]      m_err_o,
  output logic [1:0]      m_rty_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      gnt_o,
  output logic            tmo_o
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_BUSY     = 2'd1;
  localparam logic [1:0] c_TERR     = 2'd2;
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] r_gnt;
  logic [1:0] w_next_gnt;
  logic       r_last;
  logic       w_next_last;
  logic [7:0] r_cnt;
  logic [7:0] w_next_cnt;

  logic w_sel;
  logic w_own_cyc;
  logic w_own_stb;
  logic w_resp;

  assign w_sel     = r_gnt[1];
  assign w_own_cyc = m_cyc_i[w_sel];
  assign w_own_stb = m_stb_i[w_sel];
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;

  assign gnt_o   = r_gnt;
  assign m_dat_o = s_dat_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_next_gnt;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_gnt   = r_gnt;
    w_next_last  = r_last;
    w_next_cnt   = 8'd0;
    case (r_state)
      c_IDLE: begin
        if (|m_cyc_i) begin
          w_next_state = c_BUSY;
          // On contention the requester not served last wins.
          if (m_cyc_i == 2'b11) w_next_gnt = r_last ? 2'b01 : 2'b10;
          else                  w_next_gnt = m_cyc_i;
          w_next_last = w_next_gnt[1];
        end
      end
      c_BUSY: begin
        if (!w_own_cyc) begin
          w_next_state = c_IDLE;
          w_next_gnt   = 2'b00;
        end else if (w_own_stb && !w_resp) begin
          if (r_cnt == c_TMO_LAST) w_next_state = c_TERR;
          else                     w_next_cnt   = r_cnt + 8'd1;
        end
      end
      c_TERR: begin
        if (w_own_cyc) begin
          w_next_state = c_BUSY;
        end else begin
          w_next_state = c_IDLE;
          w_next_gnt   = 2'b00;
        end
      end
      default: begin
        w_next_state = c_IDLE;
        w_next_gnt   = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = 2'b00;
    m_err_o = 2'b00;
    m_rty_o = 2'b00;
    tmo_o   = 1'b0;
    case (r_state)
      c_BUSY: begin
        s_cyc_o = w_own_cyc;
        s_stb_o = w_own_stb;
        s_we_o  = m_we_i[w_sel];
        s_adr_o = w_sel ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
        s_dat_o = w_sel ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
        m_ack_o = r_gnt & {2{s_ack_i}};
        m_err_o = r_gnt & {2{s_err_i}};
        m_rty_o = r_gnt & {2{s_rty_i}};
      end
      c_TERR: begin
        m_err_o = r_gnt;
        tmo_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_wb_arbiter
// Description : Directed and randomized checks of spi_wb_arbiter against a
//               bus-ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_wb_arbiter;
  localparam int AW  = 3;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [2*AW-1:0] m_adr_i = '0;
  logic [2*DW-1:0] m_dat_i = '0;
  logic [DW-1:0]   m_dat_o;
  logic [1:0]      m_ack_o, m_err_o, m_rty_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [1:0]      gnt_o;
  logic            tmo_o;

  spi_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  always #5 clk = ~clk;

  // Ownership model: who holds the bus, who was served last, how long the
  // current strobe has gone unanswered, and whether this is a timeout slot.
  int owner, last, stall;
  bit terr;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1; stall = 0; terr = 1'b0;
  endtask

  task automatic model_step();
    bit resp;
    resp = s_ack_i | s_err_i | s_rty_i;
    if (terr) begin
      terr  = 1'b0;
      stall = 0;
      if (!m_cyc_i[owner]) owner = -1;
    end else if (owner < 0) begin
      if (m_cyc_i != 2'b00) begin
        if (m_cyc_i == 2'b11) owner = 1 - last;
        else                  owner = m_cyc_i[0] ? 0 : 1;
        last  = owner;
        stall = 0;
      end
    end else if (!m_cyc_i[owner]) begin
      owner = -1;
      stall = 0;
    end else if (m_stb_i[owner] && !resp) begin
      if (stall == TMO - 1) begin
        terr  = 1'b1;
        stall = 0;
      end else begin
        stall++;
      end
    end else begin
      stall = 0;
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    bit act;
    logic e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    eg = (owner < 0) ? 2'b00 : 2'(1 << owner);
    act = (owner >= 0) && !terr;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
    if (act) begin
      e_cyc = m_cyc_i[owner];
      e_stb = m_stb_i[owner];
      e_we  = m_we_i[owner];
      e_adr = AW'(m_adr_i >> (owner * AW));
      e_dat = DW'(m_dat_i >> (owner * DW));
    end
    chk("gnt", 32'(gnt_o), 32'(eg));
    chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
    chk("s_stb", 32'(s_stb_o), 32'(e_stb));
    chk("s_we", 32'(s_we_o), 32'(e_we));
    chk("s_adr", 32'(s_adr_o), 32'(e_adr));
    chk("s_dat", 32'(s_dat_o), 32'(e_dat));
    chk("m_ack", 32'(m_ack_o), 32'((act && s_ack_i) ? eg : 2'b00));
    chk("m_rty", 32'(m_rty_o), 32'((act && s_rty_i) ? eg : 2'b00));
    chk("m_err", 32'(m_err_o), 32'(terr ? eg : ((act && s_err_i) ? eg : 2'b00)));
    chk("tmo", 32'(tmo_o), 32'(terr));
    chk("m_dat", 32'(m_dat_o), 32'(s_dat_i));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #2;
  endtask

  task automatic rand_inputs();
    logic [1:0] cyc;
    cyc = m_cyc_i;
    for (int n = 0; n < 2; n++) begin
      if ($urandom_range(5) == 0) cyc[n] = ~cyc[n];
      m_stb_i[n] = cyc[n] & ($urandom_range(3) != 0);
    end
    m_cyc_i = cyc;
    m_we_i  = 2'($urandom);
    m_adr_i = (2*AW)'($urandom);
    m_dat_i = (2*DW)'($urandom);
    s_dat_i = DW'($urandom);
    s_ack_i = ($urandom_range(4) == 0);
    s_err_i = ($urandom_range(9) == 0);
    s_rty_i = ($urandom_range(9) == 0);
  endtask

  initial begin
    int k;
    model_reset();
    chk_en  = 1'b1;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    s_ack_i = 1'b1;
    step();
    step();
    // Active requests and responses must not leak through while in reset.
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("rst_tmo", 32'(tmo_o), 32'h0);

    // Simultaneous requests out of reset: requester 0 first, one dead cycle.
    s_ack_i = 1'b0;
    m_stb_i = 2'b00;
    rst_n   = 1'b1;
    step();
    chk("rr_first", 32'(gnt_o), 32'h1);
    m_cyc_i = 2'b10;
    step();
    chk("dead_cycle", 32'(gnt_o), 32'h0);
    step();
    chk("rr_second", 32'(gnt_o), 32'h2);
    m_cyc_i = 2'b00;
    step();
    step();

    // Requester 0 write while requester 1 waits.
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = 2'b01;
    m_adr_i = {3'd6, 3'd3};
    m_dat_i = {8'h5C, 8'hA5};
    step();
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    chk("wr_adr", 32'(s_adr_o), 32'h3);
    chk("wr_dat", 32'(s_dat_o), 32'hA5);
    chk("wr_we", 32'(s_we_o), 32'h1);
    s_ack_i = 1'b1;
    #1;
    chk("wr_ack", 32'(m_ack_o), 32'h1);
    step();
    chk("wr_locked", 32'(gnt_o), 32'h1);
    s_ack_i = 1'b0;
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    chk("wr_release", 32'(gnt_o), 32'h0);
    step();
    chk("wr_m1_gnt", 32'(gnt_o), 32'h2);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    step();

    // Unanswered strobe: timeout slot exactly TMO cycles after the strobe rises.
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    chk("tmo_stb_up", 32'(s_stb_o), 32'h1);
    for (k = 0; k < 8 && !tmo_o; k++) step();
    chk("tmo_latency", 32'(k), 32'(TMO));
    chk("tmo_err", 32'(m_err_o), 32'h1);
    chk("tmo_s_cyc", 32'(s_cyc_o), 32'h0);

    // Ack arriving at the last stalled cycle wins over the timeout.
    step();
    step();
    step();
    step();
    s_ack_i = 1'b1;
    #1;
    chk("ack_prio", 32'(m_ack_o), 32'h1);
    step();
    chk("ack_prio_no_tmo", 32'(tmo_o), 32'h0);
    s_ack_i = 1'b0;
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    step();

    repeat (1500) begin
      rand_inputs();
      step();
    end

    // Reset in the middle of a requester 1 burst.
    m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    step();
    step();
    step();
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
    step();
    step();
    rst_n   = 1'b1;
    m_cyc_i = 2'b11;
    step();
    chk("post_rst_rr", 32'(gnt_o), 32'h1);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
